// File: rtl/puf_pkg.sv
// Shared types and helpers for the PUF challenge controller.
// Holds FSM states, bus widths and the challenge LFSR step.
package puf_pkg;

    localparam int CHALLENGE_W = 8;
    localparam int RESPONSE_W  = 8;
    localparam int ENABLE_W    = 32;

    // Taps for x^8+x^6+x^5+x^4+1: feedback from bits 7,5,4,3.
    localparam logic [CHALLENGE_W-1:0] LFSR_TAPS = 8'hB8;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        LAUNCH,
        SAMPLE,
        OUTPUT
    } ctrl_state_t;

    function automatic logic [CHALLENGE_W-1:0] lfsr_next(
        input logic [CHALLENGE_W-1:0] c
    );
        return {c[CHALLENGE_W-2:0], ^(c & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/puf_majority_voter.sv
// Per-bit vote counters over repeated arbiter evaluations.
// A bit votes 1 when it was seen high in a strict majority of repeats.
module puf_majority_voter
    import puf_pkg::*;
#(
    parameter int REPEATS = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  accum,
    input  logic [RESPONSE_W-1:0] sample,
    output logic [RESPONSE_W-1:0] voted
);

    localparam logic [3:0] REP_MAX = 4'(REPEATS);
    localparam logic [3:0] HALF    = 4'(REPEATS / 2);

    logic [3:0] votes [RESPONSE_W];

    // Saturating per-bit counters; clear wins over accumulate.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < RESPONSE_W; i++) votes[i] <= '0;
        end else if (clear) begin
            for (int i = 0; i < RESPONSE_W; i++) votes[i] <= '0;
        end else if (accum) begin
            for (int i = 0; i < RESPONSE_W; i++)
                if (sample[i] && votes[i] < REP_MAX)
                    votes[i] <= votes[i] + 4'd1;
        end
    end

    // Majority decision per bit.
    always_comb begin
        voted = '0;
        for (int i = 0; i < RESPONSE_W; i++) voted[i] = votes[i] > HALF;
    end

endmodule

// File: rtl/puf_challenge_controller.sv
// Sequences LFSR challenges through the arbiter PUF array and
// streams majority-voted responses over a valid/ready port.
module puf_challenge_controller
    import puf_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4,
    parameter int REPEATS       = 3
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic [CHALLENGE_W-1:0] seed,
    input  logic [7:0]             count,
    input  logic [ENABLE_W-1:0]    enable_mask,
    output logic [CHALLENGE_W-1:0] challenge,
    output logic [ENABLE_W-1:0]    enable,
    input  logic [RESPONSE_W-1:0]  race_arbiter_out,
    output logic                   busy,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [CHALLENGE_W-1:0] resp_challenge,
    output logic [RESPONSE_W-1:0]  resp_data,
    output logic                   done
);

    localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
    localparam logic [3:0]  REP_MAX     = 4'(REPEATS);

    ctrl_state_t state, state_nxt;

    logic [15:0]           settle;
    logic [3:0]            rep_cnt;
    logic [3:0]            rep_nxt;
    logic [8:0]            remaining;
    logic                  accept;
    logic                  hs;
    logic                  last;
    logic [RESPONSE_W-1:0] voted;

    assign accept  = (state == IDLE) && start;
    assign hs      = resp_valid && resp_ready;
    assign last    = remaining == 9'd1;
    assign rep_nxt = rep_cnt + 4'd1;

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state and array-facing outputs.
    always_comb begin
        state_nxt  = state;
        enable     = '0;
        resp_valid = 1'b0;
        unique case (state)
            IDLE:   if (start) state_nxt = ARM;
            ARM:    state_nxt = LAUNCH;
            LAUNCH: begin
                enable = enable_mask;
                if (settle == SETTLE_LAST) state_nxt = SAMPLE;
            end
            SAMPLE: begin
                enable    = enable_mask;
                state_nxt = (rep_nxt < REP_MAX) ? ARM : OUTPUT;
            end
            OUTPUT: begin
                resp_valid = 1'b1;
                if (resp_ready) state_nxt = last ? IDLE : ARM;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Challenge, counters, busy and done bookkeeping.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            challenge <= '0;
            remaining <= '0;
            settle    <= '0;
            rep_cnt   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                challenge <= (seed == '0) ? 8'h01 : seed;
                remaining <= (count == '0) ? 9'd256 : {1'b0, count};
                rep_cnt   <= '0;
                busy      <= 1'b1;
            end
            if (state == ARM)    settle  <= '0;
            if (state == LAUNCH) settle  <= settle + 16'd1;
            if (state == SAMPLE) rep_cnt <= rep_nxt;
            if (hs) begin
                if (last) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end else begin
                    remaining <= remaining - 9'd1;
                    challenge <= lfsr_next(challenge);
                    rep_cnt   <= '0;
                end
            end
        end
    end

    puf_majority_voter #(.REPEATS(REPEATS)) u_voter (
        .clock  (clock),
        .reset  (reset),
        .clear  (accept || (hs && !last)),
        .accum  (state == SAMPLE),
        .sample (race_arbiter_out),
        .voted  (voted)
    );

    assign resp_data      = resp_valid ? voted : '0;
    assign resp_challenge = resp_valid ? challenge : '0;

endmodule

// File: tb/tb_puf_challenge_controller.sv
// Scoreboard bench for puf_challenge_controller.
// Stimulus pushes expected responses; a monitor pops on handshake.
module tb_puf_challenge_controller;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  seed = '0;
    logic [7:0]  count = '0;
    logic [31:0] enable_mask = 32'hDEAD_BEEF;
    logic [7:0]  challenge;
    logic [31:0] enable;
    logic [7:0]  race_arbiter_out = '0;
    logic        busy;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [7:0]  resp_challenge;
    logic [7:0]  resp_data;
    logic        done;

    puf_challenge_controller dut (
        .clock            (clock),
        .reset            (reset),
        .start            (start),
        .seed             (seed),
        .count            (count),
        .enable_mask      (enable_mask),
        .challenge        (challenge),
        .enable           (enable),
        .race_arbiter_out (race_arbiter_out),
        .busy             (busy),
        .resp_valid       (resp_valid),
        .resp_ready       (resp_ready),
        .resp_challenge   (resp_challenge),
        .resp_data        (resp_data),
        .done             (done)
    );

    always #5 clock = ~clock;

    int n_vec  = 0;
    int n_fail = 0;
    int done_cnt = 0;
    int hs_cnt = 0;
    logic [7:0] last_hs_chal = '0;
    logic [15:0] sb [$];

    logic [7:0] pat [3];
    int eval_idx = 0;
    logic en_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] model_lfsr(input logic [7:0] c);
        logic fb;
        fb = c[7] ^ c[5] ^ c[4] ^ c[3];
        return {c[6:0], fb};
    endfunction

    // Array model: a new response pattern per evaluation (enable rise).
    always @(posedge clock) begin
        #1;
        if (enable != '0 && !en_prev) begin
            race_arbiter_out = pat[eval_idx % 3];
            eval_idx++;
        end
        en_prev = enable != '0;
    end

    // Monitor: compare every handshake against the scoreboard.
    always @(negedge clock) begin
        if (reset && resp_valid && resp_ready) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL unexpected_resp: got %h/%h expected none",
                         resp_challenge, resp_data);
            end else begin
                logic [15:0] e;
                e = sb.pop_front();
                check("resp_challenge", 32'(resp_challenge), 32'(e[15:8]));
                check("resp_data", 32'(resp_data), 32'(e[7:0]));
            end
            hs_cnt++;
            last_hs_chal = resp_challenge;
        end
        if (done) begin
            done_cnt++;
            check("busy_at_done", 32'(busy), 32'd0);
        end
    end

    task automatic set_pat(input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] c);
        pat[0] = a;
        pat[1] = b;
        pat[2] = c;
        eval_idx = 0;
    endtask

    task automatic do_start(input logic [7:0] s, input logic [7:0] n);
        @(posedge clock);
        #1;
        seed  = s;
        count = n;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int limit);
        int base;
        int t;
        base = done_cnt;
        t = 0;
        while (done_cnt == base && t < limit) begin
            @(posedge clock);
            #1;
            t++;
        end
        check({name, "_done_seen"}, 32'(done_cnt - base), 32'd1);
        repeat (3) @(posedge clock);
        #1;
        check({name, "_busy_low"}, 32'(busy), 32'd0);
        check({name, "_sb_empty"}, 32'(sb.size()), 32'd0);
    endtask

    task automatic latency(input string name);
        int n;
        n = 0;
        while (!resp_valid && n < 100) begin
            @(posedge clock);
            #1;
            n++;
        end
        check(name, 32'(n), 32'd18);
    endtask

    initial begin
        int base;
        int t;
        logic [7:0] c;
        set_pat(8'hA5, 8'hA5, 8'hA5);
        #23;
        check("rst_challenge", 32'(challenge), 32'h00);
        check("rst_enable", enable, 32'h0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(resp_valid), 32'd0);
        check("rst_data", 32'(resp_data), 32'h00);
        check("rst_rchal", 32'(resp_challenge), 32'h00);
        check("rst_done", 32'(done), 32'd0);
        reset = 1'b1;

        // Three challenges, constant response.
        set_pat(8'hA5, 8'hA5, 8'hA5);
        sb.push_back({8'h01, 8'hA5});
        sb.push_back({8'h02, 8'hA5});
        sb.push_back({8'h04, 8'hA5});
        do_start(8'h01, 8'd3);
        check("busy_after_start", 32'(busy), 32'd1);
        latency("lat_first");
        wait_done("t1", 200);

        // Majority voting patterns.
        set_pat(8'hA5, 8'hA4, 8'hA5);
        sb.push_back({8'h20, 8'hA5});
        do_start(8'h20, 8'd1);
        wait_done("vote_a5", 100);
        set_pat(8'hF0, 8'h0F, 8'hFF);
        sb.push_back({8'h80, 8'hFF});
        do_start(8'h80, 8'd1);
        wait_done("vote_ff", 100);
        set_pat(8'h00, 8'hFF, 8'h00);
        sb.push_back({8'h81, 8'h00});
        do_start(8'h81, 8'd1);
        wait_done("vote_00", 100);

        // Backpressure at first OUTPUT.
        set_pat(8'hC3, 8'hC3, 8'hC3);
        resp_ready = 1'b0;
        sb.push_back({8'h5A, 8'hC3});
        sb.push_back({8'hB4, 8'hC3});
        do_start(8'h5A, 8'd2);
        latency("lat_stall");
        for (int i = 0; i < 10; i++) begin
            check("stall_valid", 32'(resp_valid), 32'd1);
            check("stall_data", 32'(resp_data), 32'hC3);
            check("stall_rchal", 32'(resp_challenge), 32'h5A);
            check("stall_enable", enable, 32'h0);
            check("stall_chal", 32'(challenge), 32'h5A);
            @(posedge clock);
            #1;
        end
        resp_ready = 1'b1;
        wait_done("stall", 100);

        // Zero seed and ignored restart.
        set_pat(8'h5A, 8'h5A, 8'h5A);
        base = hs_cnt;
        sb.push_back({8'h01, 8'h5A});
        do_start(8'h00, 8'd1);
        repeat (4) @(posedge clock);
        do_start(8'h77, 8'd5);
        wait_done("seed0", 100);
        repeat (30) @(posedge clock);
        #1;
        check("one_resp", 32'(hs_cnt - base), 32'd1);

        // Reset during LAUNCH.
        set_pat(8'h66, 8'h66, 8'h66);
        do_start(8'h10, 8'd4);
        t = 0;
        while (enable == '0 && t < 50) begin
            @(posedge clock);
            #1;
            t++;
        end
        check("launch_reached", enable, enable_mask);
        #2;
        reset = 1'b0;
        #1;
        check("rst_mid_enable", enable, 32'h0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_chal", 32'(challenge), 32'h00);
        @(posedge clock);
        #1;
        reset = 1'b1;
        set_pat(8'h66, 8'h66, 8'h66);
        sb.push_back({8'h10, 8'h66});
        do_start(8'h10, 8'd1);
        latency("lat_after_rst");
        wait_done("post_rst", 100);

        // 256 challenges from count=0.
        set_pat(8'h3C, 8'h3C, 8'h3C);
        c = 8'h01;
        for (int i = 0; i < 256; i++) begin
            sb.push_back({c, 8'h3C});
            c = model_lfsr(c);
        end
        base = hs_cnt;
        do_start(8'h01, 8'd0);
        t = 0;
        while (hs_cnt < base + 5 && t < 200) begin
            @(negedge clock);
            #1;
            t++;
        end
        check("fifth_chal", 32'(last_hs_chal), 32'h11);
        wait_done("full256", 6000);
        check("count256", 32'(hs_cnt - base), 32'd256);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/puf_challenge_controller.md
# puf_challenge_controller

Drives the parallel race-arbiter PUF array from the initiator side. It generates a sequence of 8-bit challenges from an LFSR and asserts the 32-bit enable vector for a fixed settle window. It samples the 8-bit arbiter response repeatedly per challenge and majority-votes each bit. Each voted response, paired with its challenge, is delivered over a valid/ready stream to the downstream key/ID logic.

## Interface
Parameters:
- SETTLE_CYCLES, 4: cycles enable is held before sampling; ≥1.
- REPEATS, 3: evaluations per challenge; odd, 1..15.

Ports:
- clock  in  1  sole clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request; accepted only when busy=0.
- seed  in  8  first challenge; 8'h00 is replaced by 8'h01.
- count  in  8  number of challenges; 0 means 256.
- enable_mask  in  32  pattern driven on enable during launch.
- challenge  out  8  challenge bus to the PUF array.
- enable  out  32  enable bus to the PUF array.
- race_arbiter_out  in  8  response bits from the array.
- busy  out  1  high from start acceptance until the last handshake.
- resp_valid  out  1  voted response available.
- resp_ready  in  1  downstream accepts.
- resp_challenge  out  8  challenge that produced resp_data.
- resp_data  out  8  majority-voted response.
- done  out  1  one-cycle pulse after the last response handshake.

## Operation
- States: IDLE, ARM, LAUNCH, SAMPLE, OUTPUT.
- IDLE:
  - enable=0.
  - On start, load challenge=(seed==0 ? 8'h01 : seed), remaining=count (0→256), clear vote counters and repeat counter, set busy=1, go to ARM.
- ARM: 1 cycle, enable=0, challenge stable. This clears the arbiters. Go to LAUNCH.
- LAUNCH:
  - enable=enable_mask for exactly SETTLE_CYCLES cycles, using the settle counter.
  - Go to SAMPLE.
- SAMPLE:
  - 1 cycle, enable=enable_mask.
  - Register race_arbiter_out, add each bit to its per-bit vote counter, and increment the repeat counter.
  - If repeat counter < REPEATS, go to ARM; else go to OUTPUT.
- OUTPUT:
  - enable=0. resp_valid=1.
  - resp_data[i] = (votes[i] > REPEATS/2).
  - resp_challenge = challenge.
  - On resp_valid&resp_ready:
    - If remaining==1: pulse done, set busy=0, go to IDLE.
    - Else: decrement remaining, advance the LFSR, clear the vote and repeat counters, go to ARM.
- LFSR (Fibonacci, x^8+x^6+x^5+x^4+1): next = {c[6:0], c[7]^c[5]^c[4]^c[3]}. The sequence from 8'h01 is 01,02,04,08,11,… and never reaches 00.
- Vote counters are 4 bits per response bit and saturate at REPEATS.
- start while busy=1 is ignored, with no effect on state or counters.

## Timing
- Reset values:
  - challenge=8'h00, enable=0, busy=0.
  - resp_valid=0, resp_data=0, resp_challenge=0, done=0.
  - State=IDLE.
- Reset asserted mid-operation takes effect immediately (asynchronously): enable drops to 0 and the in-flight challenge is discarded.
- One evaluation takes 2+SETTLE_CYCLES cycles (ARM, LAUNCH×SETTLE_CYCLES, SAMPLE).
- resp_valid rises REPEATS·(2+SETTLE_CYCLES) cycles after the start is accepted. With defaults this is 18 cycles.
- The next challenge's ARM begins the cycle after the handshake. This gives a per-challenge throughput of REPEATS·(2+SETTLE_CYCLES)+1 cycles with resp_ready held high.
- Backpressure: resp_valid, resp_data and resp_challenge stay stable until the handshake, and enable stays 0.
- done is high for exactly the cycle after the final handshake. busy falls in that same cycle.
- challenge changes only on entry to ARM, never while enable≠0.

## Structure
- Shared package puf_pkg:
  - ctrl_state_t enum (IDLE/ARM/LAUNCH/SAMPLE/OUTPUT).
  - LFSR_TAPS constant.
  - lfsr_next() function.
  - CHALLENGE_W=8, RESPONSE_W=8, ENABLE_W=32.
- Sub-module puf_majority_voter:
  - Contains the 8 vote counters, clear/accumulate controls, and the voted output.
  - Parameterised by REPEATS.

## Test plan
- seed=8'h01, count=3, array returns constant 8'hA5, resp_ready=1 → three responses, challenges 01,02,04, data A5 each, done after the third, busy low thereafter.
- REPEATS=3, response 8'hA5 on evaluations 1 and 3 and 8'hA4 on evaluation 2 → resp_data=8'hA5 (bit0 voted 1).
- resp_ready held low for 10 cycles at the first OUTPUT → resp_valid/resp_data/resp_challenge stable, enable=0 throughout, no LFSR advance.
- seed=8'h00, count=1 → resp_challenge=8'h01; start pulsed again during busy → ignored, exactly one response.
- Reset asserted during LAUNCH → enable=0 and busy=0 immediately; a fresh start after release → first resp_valid at cycle 18 (defaults).
- count=0, seed=8'h01 → 256 responses; the 5th challenge is 8'h11; done after the 256th handshake.
